// File: rtl/z88_ps2_kbd.sv
// z88_ps2_kbd: PS/2 keyboard receiver that maintains the 64-key Z88 keyboard matrix
// Ports:
//   clk, rst          master clock, synchronous active-high reset
//   clk_ena           clock enable; everything past the pin synchronisers advances only when high
//   ps2_clk, ps2_data asynchronous PS/2 pins (input only)
//   kb_matrix         key state, bit col*8+row, 1 = held
//   rx_err            one-enable pulse on start/parity/stop error or mid-frame timeout
//   code_vld          one-enable pulse when a good byte arrives
//   code_byte         last good byte
module z88_ps2_kbd #(
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 12500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_ena,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [63:0] kb_matrix,
    output logic        rx_err,
    output logic        code_vld,
    output logic [7:0]  code_byte
);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t         state_q, state_d;
    logic [1:0]     clk_sync_q, data_sync_q;
    logic           filt_q, filt_d;
    logic [FW-1:0]  filt_cnt_q, filt_cnt_d;
    logic           flip, strobe;
    logic [TW-1:0]  to_q, to_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic           rx_err_q, rx_err_d;
    logic           code_vld_q, code_vld_d;
    logic [7:0]     code_byte_q, code_byte_d;
    logic [63:0]    matrix_q, matrix_d;
    logic           ext_q, ext_d, brk_q, brk_d;
    logic [2:0]     skip_q, skip_d;
    logic           hit;
    logic [5:0]     idx;
    // The filtered clock flips only after FILT_LEN consecutive samples disagree with it;
    // any agreeing sample restarts the count.
    assign flip       = (clk_sync_q[1] != filt_q) && (filt_cnt_q == FW'(FILT_LEN - 1));
    assign filt_d     = flip ? ~filt_q : filt_q;
    assign filt_cnt_d = (clk_sync_q[1] == filt_q || flip) ? '0 : filt_cnt_q + 1'b1;
    assign strobe     = flip && filt_q;
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        rx_err_d    = 1'b0;
        code_vld_d  = 1'b0;
        code_byte_d = code_byte_q;
        to_d        = (strobe || state_q == IDLE) ? '0 : to_q + 1'b1;
        if (strobe) begin
            case (state_q)
                IDLE: begin
                    state_d   = data_sync_q[1] ? IDLE : DATA;
                    rx_err_d  = data_sync_q[1];
                    bit_cnt_d = '0;
                    par_d     = 1'b0;
                end
                DATA: begin
                    shift_d   = {data_sync_q[1], shift_q[7:1]};
                    par_d     = par_q ^ data_sync_q[1];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = (bit_cnt_q == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = par_q ^ data_sync_q[1];
                    state_d = STOP;
                end
                default: begin
                    // par_q now holds the xor of data and parity bits: 1 means odd parity held
                    state_d     = IDLE;
                    code_vld_d  = data_sync_q[1] && par_q;
                    rx_err_d    = !(data_sync_q[1] && par_q);
                    code_byte_d = (data_sync_q[1] && par_q) ? shift_q : code_byte_q;
                end
            endcase
        end else if (state_q != IDLE && to_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d  = IDLE;
            rx_err_d = 1'b1;
        end
    end
    always_comb begin
        hit = 1'b1;
        idx = '0;
        case ({ext_q, code_byte_q})
            9'h01C:  idx = 6'd45;
            9'h05A:  idx = 6'd6;
            9'h012:  idx = 6'd54;
            9'h059:  idx = 6'd63;
            9'h029:  idx = 6'd46;
            9'h076:  idx = 6'd61;
            9'h014:  idx = 6'd60;
            9'h011:  idx = 6'd52;
            9'h066:  idx = 6'd7;
            9'h00D:  idx = 6'd53;
            9'h175:  idx = 6'd14;
            9'h172:  idx = 6'd13;
            9'h16B:  idx = 6'd12;
            9'h174:  idx = 6'd15;
            default: hit = 1'b0;
        endcase
    end
    // Decoder runs one enable behind code_vld so it never competes with the frame FSM.
    always_comb begin
        matrix_d = matrix_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        skip_d   = skip_q;
        if (code_vld_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 1'b1;
            end else begin
                case (code_byte_q)
                    8'hE1: skip_d = 3'd7;
                    8'hE0: ext_d = 1'b1;
                    8'hF0: brk_d = 1'b1;
                    8'hAA, 8'hFC: begin
                        matrix_d = '0;
                        ext_d    = 1'b0;
                        brk_d    = 1'b0;
                    end
                    8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                        ext_d = ext_q;
                    end
                    default: begin
                        if (hit) matrix_d[idx] = ~brk_q;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                endcase
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            to_q        <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            rx_err_q    <= 1'b0;
            code_vld_q  <= 1'b0;
            code_byte_q <= '0;
            matrix_q    <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            skip_q      <= '0;
        end else if (clk_ena) begin
            state_q     <= state_d;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            to_q        <= to_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            rx_err_q    <= rx_err_d;
            code_vld_q  <= code_vld_d;
            code_byte_q <= code_byte_d;
            matrix_q    <= matrix_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            skip_q      <= skip_d;
        end
    end
    assign kb_matrix = matrix_q;
    assign rx_err    = rx_err_q;
    assign code_vld  = code_vld_q;
    assign code_byte = code_byte_q;
endmodule

// File: tb/tb_z88_ps2_kbd.sv
// tb_z88_ps2_kbd: directed and random PS/2 frames checked against a key-map model
module tb_z88_ps2_kbd;
    logic        clk = 1'b0, rst = 1'b1, clk_ena = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [63:0] kb_matrix;
    logic        rx_err, code_vld;
    logic [7:0]  code_byte;
    int          total = 0, bad = 0;
    int          n_vld = 0, n_err = 0, exp_vld = 0, exp_err = 0;
    logic [7:0]  last_byte = 8'h00;
    bit          pv = 1'b0, pe = 1'b0;
    logic [63:0] exp_m = '0;
    int          skip = 0;
    bit          ext = 1'b0, brk = 1'b0;
    int          keymap[int];
    int          rk[10] = '{'h01C, 'h05A, 'h012, 'h059, 'h029, 'h076, 'h175, 'h172, 'h014, 'h011};

    z88_ps2_kbd dut (
        .clk(clk), .rst(rst), .clk_ena(clk_ena), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .kb_matrix(kb_matrix), .rx_err(rx_err), .code_vld(code_vld), .code_byte(code_byte)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        clk_ena = ~clk_ena;
    end

    initial forever begin
        @(negedge clk);
        if (code_vld && !pv) begin
            n_vld++;
            last_byte = code_byte;
        end
        if (rx_err && !pe) n_err++;
        pv = code_vld;
        pe = rx_err;
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input int glitch_at);
        logic [10:0] f;
        int h;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        h = $urandom_range(14, 20);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (h) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (h) @(negedge clk);
            ps2_clk = 1'b1;
            if (i == glitch_at) begin
                repeat (h) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (6) @(negedge clk);
                ps2_clk = 1'b1;
            end
        end
        repeat (h) @(negedge clk);
        ps2_data = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic model_byte(input logic [7:0] b);
        int k;
        if (skip > 0) skip--;
        else if (b == 8'hE1) skip = 7;
        else if (b == 8'hE0) ext = 1'b1;
        else if (b == 8'hF0) brk = 1'b1;
        else if (b == 8'hAA || b == 8'hFC) begin
            exp_m = '0;
            ext = 1'b0;
            brk = 1'b0;
        end else if (!(b inside {8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
            k = (ext ? 256 : 0) + int'(b);
            if (keymap.exists(k)) exp_m[keymap[k]] = !brk;
            ext = 1'b0;
            brk = 1'b0;
        end
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b0, 11, -1);
        model_byte(b);
        exp_vld++;
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send_good(s[i]);
    endtask

    initial begin
        int k;
        bit rel;
        keymap['h01C] = 45; keymap['h05A] = 6;  keymap['h012] = 54; keymap['h059] = 63;
        keymap['h029] = 46; keymap['h076] = 61; keymap['h175] = 14; keymap['h172] = 13;
        keymap['h014] = 60; keymap['h011] = 52;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_matrix", kb_matrix, 64'h0);
        chk("reset_rx_err", 64'(rx_err), 64'h0);
        chk("reset_code_vld", 64'(code_vld), 64'h0);
        chk("reset_code_byte", 64'(code_byte), 64'h0);

        send_good(8'h1C);
        chk("t1_vld", 64'(n_vld), 64'(exp_vld));
        chk("t1_byte", 64'(last_byte), 64'h1C);
        chk("t1_press_1C", kb_matrix, 64'h1 << 45);
        send_seq('{8'hF0, 8'h1C});
        chk("t1_release_1C", kb_matrix, 64'h0);

        send_seq('{8'h1C, 8'hE0, 8'h75});
        chk("t2_up_press", kb_matrix, (64'h1 << 45) | (64'h1 << 14));
        send_seq('{8'hE0, 8'hF0, 8'h75});
        chk("t2_up_release", kb_matrix, 64'h1 << 45);
        send_seq('{8'h12, 8'hF0, 8'h12});
        chk("t2_ext_cleared", kb_matrix, exp_m);
        chk("t2_model", exp_m, 64'h1 << 45);

        send_frame(8'h5A, 1'b1, 11, -1);
        exp_err++;
        chk("t3_err", 64'(n_err), 64'(exp_err));
        chk("t3_no_vld", 64'(n_vld), 64'(exp_vld));
        chk("t3_matrix", kb_matrix, exp_m);

        send_frame(8'h12, 1'b0, 4, -1);
        repeat (20000) @(negedge clk);
        chk("t4_no_early_timeout", 64'(n_err), 64'(exp_err));
        repeat (10000) @(negedge clk);
        exp_err++;
        chk("t4_timeout_err", 64'(n_err), 64'(exp_err));
        send_good(8'h12);
        chk("t4_after_timeout", kb_matrix, (64'h1 << 45) | (64'h1 << 54));

        send_good(8'h29);
        chk("t5_held", kb_matrix, (64'h1 << 45) | (64'h1 << 54) | (64'h1 << 46));
        send_good(8'hAA);
        chk("t5_bat_clear", kb_matrix, 64'h0);

        send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
        chk("t6_pause_swallowed", kb_matrix, 64'h0);
        send_good(8'h76);
        chk("t6_esc", kb_matrix, 64'h1 << 61);

        send_frame(8'h5A, 1'b0, 11, 3);
        model_byte(8'h5A);
        exp_vld++;
        chk("t7_glitch_byte", 64'(last_byte), 64'h5A);
        chk("t7_glitch_matrix", kb_matrix, (64'h1 << 61) | (64'h1 << 6));
        chk("t7_glitch_err", 64'(n_err), 64'(exp_err));

        for (int it = 0; it < 16; it++) begin
            k = rk[$urandom_range(0, 9)];
            rel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) send_good(8'hFA);
            if (k >= 256) send_good(8'hE0);
            if (rel) send_good(8'hF0);
            send_good(8'(k));
            chk("rand_matrix", kb_matrix, exp_m);
        end
        chk("final_vld_count", 64'(n_vld), 64'(exp_vld));
        chk("final_err_count", 64'(n_err), 64'(exp_err));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
